// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file datapath slice (register file,
// write-port arbiter, control unit).
//   REG_DATA_W / REG_ADDR_W : register width and address width
//   NUM_REGS                : number of architectural registers
//   ZERO_REG                : address of the hard-wired $zero register
//   arb_state_t             : write-port arbiter sequencing state
package reg_file_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 3'd0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic.
//   clk    : clock, pointer updates on rising edge
//   rst    : synchronous active-high reset, pointer returns to requester 0
//   valid  : request lines, bit N = requester N
//   accept : a transfer to the granted requester happens this cycle
//   grant  : one-hot (or zero) grant, purely combinational from valid and
//            the pointer; the caller gates it with its own enable
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // rr_ptr names the requester that wins a tie.
  logic rr_ptr;

  always_comb begin
    grant    = '0;
    grant[0] = valid[0] & (~valid[1] | (rr_ptr == 1'b0));
    grant[1] = valid[1] & (~valid[0] | (rr_ptr == 1'b1));
  end

  // After serving requester N the tie goes to the other one; the pointer
  // only moves when a transfer is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Owner of the register file's single write port (WE3/A3/WD3).
// Shares the port between requester 0 (ALU writeback) and requester 1
// (load writeback) with round-robin arbitration and a valid/ready handshake.
// After every reset a clear sequence writes zero to every register; in normal
// operation accepted writes to $zero are dropped and counted.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/addr/data     : requester N write request
//   reqN_ready               : requester N write accepted this cycle
//   wr_en, wr_addr, wr_data  : registered register-file write port
//   init_done                : clear sequence finished, accepting requests
//   drop_cnt                 : saturating count of dropped $zero writes
//
// NUM_REGS must equal 2**ADDR_W; the clear counter is ADDR_W bits wide.
module reg_file_write_arbiter #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned PROTECT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic [7:0]        drop_cnt
);

  import reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              run_active;
  logic [1:0]        grant;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic              drop_inc;

  // Requesters are only served in RUN and never while reset is asserted.
  assign run_active = (state == RUN) & ~rst;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0] & run_active;
  assign req1_ready = grant[1] & run_active;
  assign accept     = req0_ready | req1_ready;

  // Grants are one-hot, so a plain select on grant[1] picks the winner.
  assign acc_addr = grant[1] ? req1_addr : req0_addr;
  assign acc_data = grant[1] ? req1_data : req0_data;

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    drop_inc    = 1'b0;

    unique case (state)
      CLEAR: begin
        // Clear writes bypass $zero protection so register 0 is zeroed too.
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = clr_cnt;
        wr_data_nxt = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          wr_addr_nxt = acc_addr;
          wr_data_nxt = acc_data;
          if ((PROTECT_ZERO != 0) && (acc_addr == ZERO_ADDR)) begin
            drop_inc = 1'b1;
          end else begin
            wr_en_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      // Registered from the current state, so it rises one cycle after
      // the last clear write becomes visible on the port.
      init_done <= (state == RUN);
      if (drop_inc && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
module tb_reg_file_write_arbiter;

  logic        clk;
  logic        rst;
  logic        r0v, r1v;
  logic [2:0]  r0a, r1a;
  logic [15:0] r0d, r1d;
  logic        r0r, r1r;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        init_done;
  logic [7:0]  drop_cnt;

  // Second instance without the clear sequence.
  logic        rst_b;
  logic        r0v_b;
  logic [2:0]  r0a_b;
  logic [15:0] r0d_b;
  logic        r0r_b, r1r_b;
  logic        wr_en_b;
  logic [2:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic        init_done_b;
  logic [7:0]  drop_cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit  m_clearing;
  int  m_clr, m_ptr, m_drop, m_addr, m_data;
  bit  m_en, m_init;
  int  m_rf[8];
  logic [15:0] d_rf[8];

  reg_file_write_arbiter #(
    .DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .CLEAR_ON_RESET(1), .PROTECT_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1r),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done), .drop_cnt(drop_cnt)
  );

  reg_file_write_arbiter #(
    .DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .CLEAR_ON_RESET(0), .PROTECT_ZERO(1)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .req0_valid(r0v_b), .req0_addr(r0a_b), .req0_data(r0d_b), .req0_ready(r0r_b),
    .req1_valid(1'b0), .req1_addr(3'd0), .req1_data(16'h0000), .req1_ready(r1r_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .init_done(init_done_b), .drop_cnt(drop_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_inputs(input bit allow_zero);
    r0v = 1'($urandom_range(0, 1));
    r1v = 1'($urandom_range(0, 1));
    r0a = 3'($urandom_range(allow_zero ? 0 : 1, 7));
    r1a = 3'($urandom_range(allow_zero ? 0 : 1, 7));
    r0d = 16'($urandom);
    r1d = 16'($urandom);
  endtask

  // One clock cycle: inputs are already driven (called at a falling edge).
  task automatic cycle();
    bit e0, e1;
    int n, a, d;
    #1;
    e0 = !rst && !m_clearing && r0v && (!r1v || m_ptr == 0);
    e1 = !rst && !m_clearing && r1v && (!r0v || m_ptr == 1);
    chk("req0_ready", 32'(r0r), 32'(e0));
    chk("req1_ready", 32'(r1r), 32'(e1));
    if (rst) begin
      m_clearing = 1'b1;
      m_clr = 0; m_ptr = 0; m_drop = 0;
      m_en = 1'b0; m_addr = 0; m_data = 0; m_init = 1'b0;
    end else begin
      m_init = !m_clearing;
      if (m_clearing) begin
        m_en = 1'b1; m_addr = m_clr; m_data = 0;
        m_rf[m_clr] = 0;
        if (m_clr == 7) m_clearing = 1'b0;
        m_clr = (m_clr + 1) % 8;
      end else if (e0 || e1) begin
        n = e0 ? 0 : 1;
        a = (n == 1) ? int'(r1a) : int'(r0a);
        d = (n == 1) ? int'(r1d) : int'(r0d);
        m_ptr = 1 - n;
        m_addr = a; m_data = d;
        if (a == 0) begin
          m_en = 1'b0;
          if (m_drop < 255) m_drop++;
        end else begin
          m_en = 1'b1;
          m_rf[a] = d;
        end
      end else begin
        m_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("wr_en", 32'(wr_en), 32'(m_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("init_done", 32'(init_done), 32'(m_init));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (wr_en === 1'b1) d_rf[wr_addr] = wr_data;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1;
    r0a = 3'd1; r1a = 3'd2; r0d = 16'h1234; r1d = 16'h5678;
    rst_b = 1'b1; r0v_b = 1'b0; r0a_b = 3'd0; r0d_b = 16'h0000;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    @(negedge clk);

    // Reset held with requests pending: nothing accepted.
    repeat (3) cycle();

    // Clear sequence, random requests must be ignored.
    rst = 1'b0;
    repeat (8) begin
      rand_inputs(1'b1);
      cycle();
    end
    r0v = 1'b0; r1v = 1'b0;
    cycle();
    chk("init_after_clear", 32'(init_done), 32'd1);

    // Single requester 0 write.
    r0v = 1'b1; r0a = 3'd3; r0d = 16'hBEEF;
    cycle();
    chk("single_data", 32'(wr_data), 32'h0000BEEF);
    r0v = 1'b0;
    cycle();
    chk("single_en_off", 32'(wr_en), 32'd0);

    // Single requester 1 write, returns the tie to requester 0.
    r1v = 1'b1; r1a = 3'd2; r1d = 16'h1234;
    cycle();
    r1v = 1'b0;
    cycle();

    // Contention on the same address: alternating winners.
    r0v = 1'b1; r0a = 3'd5; r0d = 16'h1111;
    r1v = 1'b1; r1a = 3'd5; r1d = 16'h2222;
    repeat (4) cycle();
    chk("contend_last", 32'(wr_data), 32'h00002222);
    r0v = 1'b0; r1v = 1'b0;
    cycle();

    // $zero protection and drop counter saturation.
    r1v = 1'b1; r1a = 3'd0; r1d = 16'hFFFF;
    repeat (300) cycle();
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    r1v = 1'b0;
    cycle();

    // Randomised traffic with occasional resets.
    repeat (200) begin
      rand_inputs(1'b1);
      rst = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0; r0v = 1'b0; r1v = 1'b0;
    repeat (10) cycle();

    // Accept then reset: the write is visible, then reset clears it.
    r0v = 1'b1; r0a = 3'd4; r0d = 16'hABCD;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_kills_wr", 32'(wr_en), 32'd0);
    // Request during reset: never accepted, never written.
    cycle();
    rst = 1'b0; r0v = 1'b0;
    cycle();
    chk("clear_restart", 32'(wr_addr), 32'd0);
    repeat (8) cycle();

    // Random traffic to finish, no resets.
    repeat (80) begin
      rand_inputs(1'b1);
      cycle();
    end
    r0v = 1'b0; r1v = 1'b0;
    cycle();

    for (int i = 0; i < 8; i++) chk($sformatf("regfile%0d", i), 32'(d_rf[i]), 32'(m_rf[i]));

    // Variant without the clear sequence.
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_init", 32'(init_done_b), 32'd0);
    chk("b_rst_wr_en", 32'(wr_en_b), 32'd0);
    @(negedge clk);
    rst_b = 1'b0; r0v_b = 1'b1; r0a_b = 3'd7; r0d_b = 16'h7777;
    #1;
    chk("b_ready_now", 32'(r0r_b), 32'd1);
    @(posedge clk); #1;
    chk("b_wr_en", 32'(wr_en_b), 32'd1);
    chk("b_wr_addr", 32'(wr_addr_b), 32'd7);
    chk("b_wr_data", 32'(wr_data_b), 32'h7777);
    chk("b_init", 32'(init_done_b), 32'd1);
    @(negedge clk);
    r0v_b = 1'b0;
    @(posedge clk); #1;
    chk("b_wr_en_off", 32'(wr_en_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
